// File: rtl/buff_uart_pkg.sv
// Shared types for the buffered UART path: pop FSM state encoding and default word width.
package buff_uart_pkg;

  localparam int UART_WORD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } tx_fifo_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer write port and transmitter offer port of uart_tx_fifo.
// Optional occupancy signal `level` is present when UART_TX_FIFO_LEVEL_EN is defined.
interface uart_tx_fifo_if
  import buff_uart_pkg::*;
#(
  parameter int WIDTH = UART_WORD_WIDTH,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Write port: a word moves on every rising edge where wr_valid && wr_ready.
  // Offer port: tx_data is valid and stable while tx_can_send is high; the
  // transmitter acknowledges by dropping tx_ready, which retires the word.
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             tx_ready;
  logic             tx_can_send;
  logic [WIDTH-1:0] tx_data;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [CW-1:0]    level;

  modport master (
    output wr_valid, wr_data, tx_ready,
    input  wr_ready, tx_can_send, tx_data, level
  );
  modport slave (
    input  wr_valid, wr_data, tx_ready,
    output wr_ready, tx_can_send, tx_data, level
  );
`else
  modport master (
    output wr_valid, wr_data, tx_ready,
    input  wr_ready, tx_can_send, tx_data
  );
  modport slave (
    input  wr_valid, wr_data, tx_ready,
    output wr_ready, tx_can_send, tx_data
  );
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// Storage array with wrapping read/write pointers and an occupancy counter.
// The caller guarantees push only when not full and pop only when not empty.
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Contents need no reset: a cleared count makes every stored word unreachable.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_q;
  assign full    = (count_q == FULL_COUNT);

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; a word is retired only on the transmitter's ready-fall ack.
// Define UART_TX_FIFO_LEVEL_EN to expose the occupancy count as bus.level.
module uart_tx_fifo
  import buff_uart_pkg::*;
#(
  parameter int WIDTH = UART_WORD_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus,
  output tx_fifo_state_t dbg_state
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic             full;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rd_data;

  tx_fifo_state_t   state;
  logic             can_send_q;
  logic [WIDTH-1:0] data_q;

  assign push = bus.wr_valid && !full;
  // tx_ready high alone proves nothing (stop bit may still be timing); only its fall in OFFER retires.
  assign pop  = (state == OFFER) && !bus.tx_ready;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (bus.wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .count   (count),
    .full    (full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      can_send_q <= 1'b0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          can_send_q <= 1'b0;
          if (count != '0 && bus.tx_ready) begin
            state      <= OFFER;
            data_q     <= rd_data;
            can_send_q <= 1'b1;
          end
        end
        OFFER: begin
          if (!bus.tx_ready) begin
            state      <= BUSY;
            can_send_q <= 1'b0;
          end
        end
        BUSY: begin
          can_send_q <= 1'b0;
          if (bus.tx_ready) begin
            if (count != '0) begin
              state      <= OFFER;
              data_q     <= rd_data;
              can_send_q <= 1'b1;
            end else if (push) begin
              // Empty queue but a word lands this edge: forward it straight from the write port.
              state      <= OFFER;
              data_q     <= bus.wr_data;
              can_send_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          can_send_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ready    = !full;
  assign bus.tx_can_send = can_send_q;
  assign bus.tx_data     = data_q;
  assign dbg_state       = state;
`ifdef UART_TX_FIFO_LEVEL_EN
  assign bus.level       = count;
`endif

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO placed directly upstream of the UART transmitter in the buffered UART path. Producers push words through a valid/ready write port. The block offers the oldest word to the transmitter through its `can_send_next_word`/`data`/`ready` handshake. It removes each word only after the transmitter has taken it, so bytes are neither lost nor duplicated while the transmitter is mid-frame.

## Interface
Parameters:
- `WIDTH`, 8: data word width; must match the transmitter word width.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.

Ports:
- `clock`  in  1: sole clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `wr_valid`  in  1: producer offers `wr_data`.
- `wr_ready`  out  1: FIFO can accept a word.
- `wr_data`  in  WIDTH: word to enqueue.
- `tx_ready`  in  1: transmitter idle/ready flag.
- `tx_can_send`  out  1: drives the transmitter's `can_send_next_word`.
- `tx_data`  out  WIDTH: word offered to the transmitter.
- `level`  out  $clog2(DEPTH)+1: occupancy. Present only with `UART_TX_FIFO_LEVEL_EN`.

## Operation
Storage:
- `DEPTH`-entry memory with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- `count` register, $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Push occurs when `wr_valid && wr_ready` at a clock edge.
- `wr_ready = (count != DEPTH)`, decoded from registered state.

Pop FSM (`IDLE`, `OFFER`, `BUSY`):
- `IDLE`: `tx_can_send`=0. Goes to `OFFER` when `count != 0 && tx_ready`. On that transition, load `tx_data <= mem[rd_ptr]`.
- `OFFER`: `tx_can_send`=1 and `tx_data` is held stable. A `tx_ready` low sample means the transmitter has latched the word. Then pop (`rd_ptr++`, `count--`) and go to `BUSY`.
- `BUSY`: `tx_can_send`=0. Waits for `tx_ready`=1 (transmitter finished the stop bit). Then go to `OFFER` if `count != 0` (count after any same-cycle push, loading `tx_data`), else `IDLE`.
- An unreachable encoding returns to `IDLE`.

Pop rule:
- Popping keys off the `tx_ready` falling acknowledgement, never off `tx_ready` high alone. The transmitter may show ready while still timing the stop bit.

Simultaneous push and pop: `count` is unchanged and both pointers advance.

Reset (including mid-frame):
- Pointers, `count`, FSM=`IDLE`, `tx_can_send`=0, `tx_data`=0.
- Stored words are discarded.
- `wr_ready` is 1 from the first cycle after reset.

## Timing
- Write to an empty FIFO at edge k:
  - `count`=1 after edge k.
  - FSM enters `OFFER` at edge k+1 if `tx_ready`=1.
  - `tx_can_send` is high from k+1.
- Pop occurs at the first edge where `OFFER` samples `tx_ready`=0. Since the transmitter drops ready one cycle after acceptance, this is the cycle after the transmitter accepts.
- `tx_can_send` falls together with the pop. The transmitter never sees it high for two acceptances.
- Minimum spacing between offers: the transmitter's ready-low period plus 1 cycle.
- All outputs are registered or decoded from registers; there is no combinational path from inputs to outputs.

## Configuration
- `UART_TX_FIFO_LEVEL_EN` defined: port `level` exists and equals `count`; reset value 0.
- Not defined: the port is absent. `count` remains internal and behaviour is otherwise identical.

## Structure
- Shared package `buff_uart_pkg` holds:
  - the FSM enum `tx_fifo_state_t` (`IDLE`, `OFFER`, `BUSY`);
  - the default width constant `UART_WORD_WIDTH` = 8.
- One natural sub-module: `sync_fifo_mem`, holding the storage array, pointers and count. The top level holds the pop FSM and `tx_data` register.

## Test plan
- Reset, then idle: `wr_ready`=1, `tx_can_send`=0, `tx_data`=0, and (with LEVEL_EN) `level`=0.
- Push 0xA5 with `tx_ready`=1 held: `tx_can_send` rises 1 cycle after the push with `tx_data`=0xA5. Drop `tx_ready` → pop, `tx_can_send`=0, count 0.
- Push 0x11, 0x22, 0x33 back-to-back; the transmitter model holds ready low for 20 cycles per word. Required: offers appear in order 0x11, 0x22, 0x33, each exactly once.
- Hold `tx_ready`=1 while staying in `OFFER` for 50 cycles: no pop, data stable, count unchanged.
- Fill with 16 words, then push while popping: `wr_ready`=0 at full, no overwrite, and a push on the pop cycle's next edge is accepted. Pointers wrap; 20 words total are sent in order.
- Assert `reset` in `BUSY` with 5 words queued: all outputs return to reset values next cycle, and the old words are never offered.
